// File: rtl/store_data_narrower_pkg.sv
// Shared types for the store data narrower: access-size encoding,
// controller states, lane-image geometry and a size-to-byte-mask helper.
package store_data_narrower_pkg;

  // Access size as carried on request_size.
  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'b00,
    SIZE_HALF   = 2'b01,
    SIZE_WORD   = 2'b10,
    SIZE_DOUBLE = 2'b11
  } store_size_e;

  // Controller states: waiting for a request, or emitting its beats.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } narrower_state_e;

  // A doubleword at byte offset 3 touches three consecutive bus words.
  localparam int unsigned IMAGE_WORDS = 3;
  localparam int unsigned ADDR_WIDTH  = 32;

  // Mask of the low bytes of the store operand that the access writes.
  function automatic logic [7:0] size_byte_mask(input store_size_e size);
    case (size)
      SIZE_BYTE:   return 8'h01;
      SIZE_HALF:   return 8'h03;
      SIZE_WORD:   return 8'h0F;
      default:     return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/store_data_narrower_if.sv
// Request channel and memory write channel of the store data narrower.
// The slave modport is the narrower itself; master is its environment.
interface store_data_narrower_if #(
  parameter int REGISTER_WIDTH = 64,
  parameter int BUS_WIDTH      = 32
);
  import store_data_narrower_pkg::*;

  logic                      request_valid;
  logic                      request_ready;
  logic [ADDR_WIDTH-1:0]     request_address;
  logic [1:0]                request_size;
  logic [REGISTER_WIDTH-1:0] request_data;

  logic                      memory_valid;
  logic                      memory_ready;
  logic [ADDR_WIDTH-1:0]     memory_address;
  logic [BUS_WIDTH-1:0]      memory_data;
  logic [BUS_WIDTH/8-1:0]    memory_strobe;
  logic                      memory_last;

  modport slave (
    input  request_valid, request_address, request_size, request_data, memory_ready,
    output request_ready, memory_valid, memory_address, memory_data, memory_strobe,
           memory_last
  );

  modport master (
    output request_valid, request_address, request_size, request_data, memory_ready,
    input  request_ready, memory_valid, memory_address, memory_data, memory_strobe,
           memory_last
  );

endinterface

// File: rtl/store_data_narrower_lane_aligner.sv
// Combinational lane aligner: keeps the low N bytes of the store operand
// and shifts them, with their byte strobes, to the address byte offset
// inside a three-word lane image.
module store_lane_aligner
  import store_data_narrower_pkg::*;
#(
  parameter int REGISTER_WIDTH = 64,
  parameter int BUS_WIDTH      = 32
) (
  input  logic [1:0]                           offset,
  input  store_size_e                          size,
  input  logic [REGISTER_WIDTH-1:0]            data,
  output logic [IMAGE_WORDS*BUS_WIDTH-1:0]     lanes,
  output logic [IMAGE_WORDS*BUS_WIDTH/8-1:0]   strobes
);

  localparam int IMAGE_BITS  = IMAGE_WORDS * BUS_WIDTH;
  localparam int IMAGE_BYTES = IMAGE_BITS / 8;
  localparam int REG_BYTES   = REGISTER_WIDTH / 8;

  logic [7:0]                w_byte_mask;
  logic [REGISTER_WIDTH-1:0] w_kept;
  logic [IMAGE_BITS-1:0]     w_kept_wide;
  logic [IMAGE_BYTES-1:0]    w_mask_wide;

  // Drop operand bytes above the access size so they never reach a lane.
  always_comb begin
    // NOTE: every variable assigned here gets a value on every path first,
    // otherwise synthesis infers a latch to hold the old value.
    w_byte_mask = size_byte_mask(size);
    w_kept      = '0;
    for (int b = 0; b < REG_BYTES; b++) begin
      if (w_byte_mask[b]) w_kept[8*b +: 8] = data[8*b +: 8];
    end
  end

  assign w_kept_wide = {{(IMAGE_BITS - REGISTER_WIDTH){1'b0}}, w_kept};
  assign w_mask_wide = {{(IMAGE_BYTES - 8){1'b0}}, w_byte_mask};

  assign lanes   = w_kept_wide << {offset, 3'b000};
  assign strobes = w_mask_wide << offset;

endmodule

// File: rtl/store_data_narrower.sv
// Store data narrower: accepts one register-width store, then emits it as
// 1..3 word-aligned write beats with byte strobes, lowest address first.
module store_data_narrower
  import store_data_narrower_pkg::*;
#(
  parameter int REGISTER_WIDTH = 64,
  parameter int BUS_WIDTH      = 32
) (
  input logic                 clock,
  input logic                 reset_n,
  store_data_narrower_if.slave bus
);

  localparam int BUS_BYTES = BUS_WIDTH / 8;

  narrower_state_e r_state;
  narrower_state_e w_state_next;
  logic            r_started;

  logic [ADDR_WIDTH-3:0]                       r_word_addr;
  logic [IMAGE_WORDS-1:0][BUS_WIDTH-1:0]       r_lanes;
  logic [IMAGE_WORDS-1:0][BUS_BYTES-1:0]       r_strobes;
  logic [1:0]                                  r_beat;
  logic [1:0]                                  r_last_beat;

  logic [IMAGE_WORDS*BUS_WIDTH-1:0]            w_lanes;
  logic [IMAGE_WORDS*BUS_BYTES-1:0]            w_strobes;
  logic [1:0]                                  w_last_beat;
  logic                                        w_accept;
  logic                                        w_beat_done;
  logic                                        w_is_last;

  logic                      w_request_ready;
  logic                      w_memory_valid;
  logic [ADDR_WIDTH-1:0]     w_memory_address;
  logic [BUS_WIDTH-1:0]      w_memory_data;
  logic [BUS_BYTES-1:0]      w_memory_strobe;
  logic                      w_memory_last;

  store_lane_aligner #(
    .REGISTER_WIDTH (REGISTER_WIDTH),
    .BUS_WIDTH      (BUS_WIDTH)
  ) u_aligner (
    .offset  (bus.request_address[1:0]),
    .size    (store_size_e'(bus.request_size)),
    .data    (bus.request_data),
    .lanes   (w_lanes),
    .strobes (w_strobes)
  );

  // Final beat index = highest image word with any strobe set; the touched
  // words are contiguous and always start at word 0.
  always_comb begin
    w_last_beat = 2'd0;
    if (|w_strobes[2*BUS_BYTES +: BUS_BYTES])      w_last_beat = 2'd2;
    else if (|w_strobes[BUS_BYTES +: BUS_BYTES])   w_last_beat = 2'd1;
  end

  assign w_accept    = bus.request_valid && w_request_ready;
  assign w_beat_done = w_memory_valid && bus.memory_ready;
  assign w_is_last   = (r_beat == r_last_beat);

  // State register; r_started keeps request_ready low until the first
  // clock edge after reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_started <= 1'b1;
    end
  end

  // Next-state logic: leave IDLE on acceptance, return when the last beat
  // is taken by memory.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)                 w_state_next = ST_SEND;
      ST_SEND: if (w_beat_done && w_is_last) w_state_next = ST_IDLE;
      default:                               w_state_next = ST_IDLE;
    endcase
  end

  // Request capture and beat counter; nothing changes while in SEND except
  // the beat index, so late request_valid pulses cannot disturb a store.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: the captured image is reset as well, so a store cut short by
    // reset leaves no stale beat behind to be reissued.
    if (!reset_n) begin
      r_word_addr <= '0;
      r_lanes     <= '0;
      r_strobes   <= '0;
      r_beat      <= 2'd0;
      r_last_beat <= 2'd0;
    end else if (w_accept) begin
      r_word_addr <= bus.request_address[ADDR_WIDTH-1:2];
      r_lanes     <= w_lanes;
      r_strobes   <= w_strobes;
      r_beat      <= 2'd0;
      r_last_beat <= w_last_beat;
    end else if (w_beat_done) begin
      r_beat <= w_is_last ? 2'd0 : r_beat + 2'd1;
    end
  end

  // Outputs decoded from the state: beats only in SEND, everything zero
  // otherwise; address arithmetic wraps naturally at 2^32.
  always_comb begin
    w_request_ready  = 1'b0;
    w_memory_valid   = 1'b0;
    w_memory_address = '0;
    w_memory_data    = '0;
    w_memory_strobe  = '0;
    w_memory_last    = 1'b0;
    case (r_state)
      ST_IDLE: w_request_ready = r_started;
      ST_SEND: begin
        w_memory_valid   = 1'b1;
        w_memory_address = {r_word_addr, 2'b00} + {28'd0, r_beat, 2'b00};
        w_memory_data    = r_lanes[r_beat];
        w_memory_strobe  = r_strobes[r_beat];
        w_memory_last    = w_is_last;
      end
      default: ;
    endcase
  end

  assign bus.request_ready  = w_request_ready;
  assign bus.memory_valid   = w_memory_valid;
  assign bus.memory_address = w_memory_address;
  assign bus.memory_data    = w_memory_data;
  assign bus.memory_strobe  = w_memory_strobe;
  assign bus.memory_last    = w_memory_last;

endmodule

// File: tb/tb_store_data_narrower.sv
// Bench for store_data_narrower: directed corner stores, a back-pressure
// and reset scenario, then random stores, all against a byte-level model.
module tb_store_data_narrower;
  import store_data_narrower_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  store_data_narrower_if #(.REGISTER_WIDTH(64), .BUS_WIDTH(32)) bus ();

  store_data_narrower #(
    .REGISTER_WIDTH (64),
    .BUS_WIDTH      (32)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the N written bytes one address at a time; each byte
  // lands on lane addr%4 of word addr&~3, and each new word is a new beat.
  function automatic void build_model(input logic [31:0] addr, input logic [1:0] size,
                                      input logic [63:0] data);
    int          n;
    int          lane;
    logic [31:0] a;
    logic [31:0] wa;
    beat_t       cur;
    bit          have;
    n    = 1 << size;
    have = 1'b0;
    cur  = '{addr: 32'h0, data: 32'h0, strb: 4'h0};
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a    = addr + 32'(i);
      wa   = {a[31:2], 2'b00};
      lane = int'(a[1:0]);
      if (have && cur.addr != wa) begin
        exp_q.push_back(cur);
        have = 1'b0;
      end
      if (!have) begin
        cur  = '{addr: wa, data: 32'h0, strb: 4'h0};
        have = 1'b1;
      end
      cur.data[8*lane +: 8] = data[8*i +: 8];
      cur.strb[lane]        = 1'b1;
    end
    exp_q.push_back(cur);
  endfunction

  // Wait (bounded) at falling edges for request_ready; memory_ready is
  // toggled meanwhile, which must have no effect with no beat present.
  task automatic wait_ready(input string tag);
    for (int i = 0; i < 8; i++) begin
      if (bus.request_ready === 1'b1) break;
      bus.memory_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    check({tag, " ready"}, bus.request_ready, 1'b1);
  endtask

  // One store. mode 0: memory always ready; 1: random stalls;
  // 2: five stall cycles on beat 0 with request_valid pulses meanwhile.
  task automatic run_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic [63:0] data, input int mode);
    int stall;
    wait_ready(tag);
    bus.memory_ready    = 1'b0;
    bus.request_valid   = 1'b1;
    bus.request_address = addr;
    bus.request_size    = size;
    bus.request_data    = data;
    build_model(addr, size, data);
    @(posedge clock);
    @(negedge clock);
    bus.request_valid   = 1'b0;
    bus.request_address = $urandom;
    bus.request_size    = 2'($urandom_range(0, 3));
    bus.request_data    = {$urandom, $urandom};
    for (int k = 0; k < exp_q.size(); k++) begin
      stall = (mode == 2 && k == 0) ? 5 : (mode == 1) ? int'($urandom_range(0, 2)) : 0;
      for (int c = 0; c <= stall; c++) begin
        check($sformatf("%s b%0d valid", tag, k), bus.memory_valid, 1'b1);
        check($sformatf("%s b%0d addr", tag, k), bus.memory_address, exp_q[k].addr);
        check($sformatf("%s b%0d data", tag, k), bus.memory_data, exp_q[k].data);
        check($sformatf("%s b%0d strb", tag, k), bus.memory_strobe, exp_q[k].strb);
        check($sformatf("%s b%0d last", tag, k), bus.memory_last, k == exp_q.size() - 1);
        check($sformatf("%s b%0d req_rdy", tag, k), bus.request_ready, 1'b0);
        bus.memory_ready = (c == stall);
        if (mode == 2 && c < stall) begin
          bus.request_valid   = (c % 2 == 0);
          bus.request_address = $urandom;
          bus.request_size    = 2'($urandom_range(0, 3));
          bus.request_data    = {$urandom, $urandom};
        end
        @(posedge clock);
        @(negedge clock);
        bus.request_valid = 1'b0;
      end
    end
    bus.memory_ready = 1'b0;
    check({tag, " done valid"}, bus.memory_valid, 1'b0);
    check({tag, " done ready"}, bus.request_ready, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " valid"}, bus.memory_valid, 1'b0);
    check({tag, " last"}, bus.memory_last, 1'b0);
    check({tag, " addr"}, bus.memory_address, 32'h0);
    check({tag, " data"}, bus.memory_data, 32'h0);
    check({tag, " strb"}, bus.memory_strobe, 4'h0);
    check({tag, " req_rdy"}, bus.request_ready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus.request_valid   = 1'b0;
    bus.request_address = '0;
    bus.request_size    = '0;
    bus.request_data    = '0;
    bus.memory_ready    = 1'b0;
    reset_n             = 1'b0;

    // Reset state, and request_ready only after the first post-release edge.
    #2;
    check_all_zero("reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    check({"release"}, bus.request_ready, 1'b0);
    @(negedge clock);
    check({"post-release"}, bus.request_ready, 1'b1);

    // Directed corner stores; upper operand bits beyond the size are junk.
    run_store("byte_1003", 32'h0000_1003, SIZE_BYTE, 64'hDEAD_BEEF_CAFE_12AB, 0);
    run_store("dw_2000", 32'h0000_2000, SIZE_DOUBLE, 64'h1122_3344_5566_7788, 0);
    run_store("dw_3002", 32'h0000_3002, SIZE_DOUBLE, 64'h0102_0304_0506_0708, 1);
    run_store("half_wrap", 32'hFFFF_FFFF, SIZE_HALF, 64'h5555_AAAA_9999_BEEF, 0);
    run_store("stall", 32'h0000_6001, SIZE_WORD, 64'h0BAD_F00D_A1B2_C3D4, 2);

    // Reset during beat 1 of a three-beat store.
    wait_ready("rst_store");
    bus.request_valid   = 1'b1;
    bus.request_address = 32'h0000_5001;
    bus.request_size    = SIZE_DOUBLE;
    bus.request_data    = 64'hFEDC_BA98_7654_3210;
    @(posedge clock);
    @(negedge clock);
    bus.request_valid = 1'b0;
    bus.memory_ready  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.memory_ready = 1'b0;
    check("rst b1 valid", bus.memory_valid, 1'b1);
    check("rst b1 addr", bus.memory_address, 32'h0000_5004);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clock);
    reset_n = 1'b1;
    check_all_zero("rst_release");
    @(negedge clock);
    check("rst_after valid", bus.memory_valid, 1'b0);
    run_store("word_4000", 32'h0000_4000, SIZE_WORD, 64'h0000_0000_CAFE_BABE, 0);
    @(negedge clock);
    check("word_4000 no extra beat", bus.memory_valid, 1'b0);

    // Random stores of every size and alignment under random back-pressure.
    for (int t = 0; t < 40; t++) begin
      run_store($sformatf("rnd%0d", t), $urandom, 2'($urandom_range(0, 3)),
                {$urandom, $urandom}, int'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_data_narrower.md
STORE_DATA_NARROWER -- requirements
Module: store_data_narrower

Interface
REQ-001 SHALL have parameter REGISTER_WIDTH, default 64, the width of the store data register operand.
REQ-002 SHALL have parameter BUS_WIDTH, default 32, the memory write data width; REGISTER_WIDTH == 2*BUS_WIDTH is required.
REQ-003 SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port request_valid  input  1  store request present.
REQ-006 SHALL have port request_ready  output  1  block can accept a request.
REQ-007 SHALL have port request_address  input  32  byte address of the store.
REQ-008 SHALL have port request_size  input  2  access size: 00 byte, 01 half, 10 word, 11 double.
REQ-009 SHALL have port request_data  input  REGISTER_WIDTH  store value, right-justified; bits above the size are ignored.
REQ-010 SHALL have port memory_valid  output  1  write beat present.
REQ-011 SHALL have port memory_ready  input  1  memory accepts the beat.
REQ-012 SHALL have port memory_address  output  32  word-aligned beat address, bits [1:0] always 0.
REQ-013 SHALL have port memory_data  output  BUS_WIDTH  beat data on the byte lanes.
REQ-014 SHALL have port memory_strobe  output  BUS_WIDTH/8  byte-lane write enables.
REQ-015 SHALL have port memory_last  output  1  marks the final beat of a request.

Function
REQ-016 SHALL use FSM states IDLE and SEND: request_ready = 1 only in IDLE; request_valid && request_ready in IDLE captures address, size and data and moves to SEND.
REQ-017 SHALL use byte count N = 1/2/4/8 for size 00/01/10/11 and offset = request_address[1:0].
REQ-018 SHALL place the low N bytes of request_data at byte positions offset..offset+N-1 of a 3-word (96-bit) lane image, with a 12-bit strobe image set on exactly those positions.
REQ-019 SHALL emit one beat per word of the image whose strobe nibble is nonzero, in ascending order; beat count is 1..3, and a misaligned doubleword needs 3 beats.
REQ-020 SHALL drive beat k with memory_address = {request_address[31:2],2'b00} + 4*k, modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
REQ-021 SHALL drive memory_data lanes whose strobe is 0 to zero.
REQ-022 SHALL assert memory_valid on the cycle after acceptance; first-beat latency is 1 cycle.
REQ-023 SHALL hold memory_valid, address, data, strobe and last stable while memory_valid && !memory_ready.
REQ-024 SHALL advance to the next beat on memory_valid && memory_ready, presenting it on the following cycle with no bubble.
REQ-025 SHALL assert memory_last only on the final beat; acceptance of that beat returns the FSM to IDLE, so request_ready rises on the next cycle, with no same-cycle overlap.
REQ-026 SHALL ignore request_valid while in SEND and SHALL NOT change the captured request.
REQ-027 SHALL ignore memory_ready while memory_valid = 0.

Reset
REQ-028 SHALL on reset_n = 0 force, immediately and asynchronously, state IDLE, beat counter 0, memory_valid 0, memory_last 0, memory_address/data/strobe 0 and request_ready 0; request_ready rises the first cycle after reset_n deasserts.
REQ-029 SHALL on reset mid-SEND discard remaining beats, with no partial beat reissued after reset release.

Structure
REQ-030 SHALL define the size encoding (typedef enum: byte/half/word/double) and the state enum in a shared package, e.g. dragonfang_memory_pkg.
REQ-031 SHALL implement the lane/strobe image computation as the combinational sub-module store_lane_aligner (inputs offset, size, data; outputs 96-bit lanes, 12-bit strobes).

Verification
REQ-032 SHALL cover: byte store, address 0x1003, data 0xAB -> 1 beat, addr 0x1000, strobe 1000, data 0xAB000000, last = 1.
REQ-033 SHALL cover: aligned doubleword, address 0x2000, data 0x1122334455667788 -> beats (0x2000, 0x55667788, 1111), then (0x2004, 0x11223344, 1111, last).
REQ-034 SHALL cover: misaligned doubleword, address 0x3002 -> 3 beats with strobes 1100, 1111, 0011 at 0x3000/0x3004/0x3008.
REQ-035 SHALL cover: halfword at 0xFFFFFFFF -> beats at 0xFFFFFFFC (strobe 1000) then 0x00000000 (strobe 0001, last).
REQ-036 SHALL cover: memory_ready held low 5 cycles on beat 0 -> outputs stable; request_valid pulses in SEND ignored.
REQ-037 SHALL cover: reset_n low during beat 1 of a 3-beat store -> all outputs 0 at once; after release, a new word store at 0x4000 produces exactly 1 beat.
